adc_poll_ctrl: RTL and testbench
================================

// Module: adc_poll_ctrl
// PURPOSE
//  APB master that periodically reads the APB ADC slave and buffers results.
//  - Issues single read transfers at a programmed interval.
//  - Tolerates slave wait states, with a timeout.
//  - Extracts the 14-bit code from PRDATA[31:18] into a small FIFO for a downstream consumer.
//  - Sits between the ADC's APB slave port and the sample-processing logic.
// PARAMETERS
//  DEPTH    4   sample FIFO depth (power of 2, >=2)
//  IW       16  width of interval counter / interval input
//  TIMEOUT  16  max ACCESS cycles without PREADY before abort (>=2)
// PORTS
//  PCLK       in   1   clock; all logic on posedge
//  PRESET     in   1   asynchronous reset, active low
//  enable     in   1   1 = keep polling; 0 = stop after current transfer
//  interval   in   IW  idle cycles between end of one transfer and next SETUP
//  clr_err    in   1   1-cycle pulse: clears all sticky error flags
//  PSEL       out  1   APB select to ADC
//  PENABLE    out  1   APB enable to ADC
//  PWRITE     out  1   APB direction; always 0 (read only)
//  PREADY     in   1   APB ready from ADC
//  PRDATA     in   32  APB read data from ADC
//  PSLVERR    in   1   APB slave error from ADC
//  smp_valid  out  1   FIFO not empty
//  smp_data   out  14  head-of-FIFO sample (PRDATA[31:18] of that transfer)
//  smp_fs     out  1   head sample is full scale (smp_data==14'h3FFF)
//  smp_pop    in   1   consumer pops head when smp_valid=1
//  to_err     out  1   sticky: a transfer timed out
//  slv_err    out  1   sticky: a transfer completed with PSLVERR=1
//  ovf_err    out  1   sticky: a sample was dropped, FIFO full
// BEHAVIOUR
//  Reset (PRESET=0, async): state IDLE, all outputs 0, FIFO empty, counters 0.
//  FSM states: IDLE, SETUP, ACCESS, WAIT.
//   - IDLE: PSEL=0, PENABLE=0. enable=1 -> SETUP next cycle.
//   - SETUP: PSEL=1, PENABLE=0, one cycle only -> ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1. Stays while PREADY=0; wait counter increments.
//       - PREADY=1 at posedge: transfer completes -> WAIT.
//           - PSLVERR=0: push PRDATA[31:18]; PRDATA[17:0] ignored.
//           - PSLVERR=1: no push, set slv_err.
//       - Counter reaches TIMEOUT with PREADY=0: abort (PSEL, PENABLE -> 0),
//         set to_err, no push -> WAIT.
//   - WAIT: PSEL=0, PENABLE=0. Interval counter loads interval on entry, counts down.
//       - At 0: enable=1 -> SETUP; enable=0 -> IDLE.
//       - interval=0 -> WAIT lasts exactly one cycle.
//  APB outputs are registered. PSEL/PENABLE are never both high outside ACCESS.
//  PRDATA is sampled only when PREADY=1 in ACCESS.
//  enable falling during SETUP/ACCESS: transfer still finishes (or times out),
//  then WAIT -> IDLE. interval is sampled on WAIT entry only.
//  FIFO:
//   - Push takes effect at the completing edge; smp_valid=1 on the next cycle.
//   - Pop when smp_valid=1 and smp_pop=1. Pop when empty is ignored.
//   - Push while full with no pop: new sample dropped, ovf_err set, contents unchanged.
//   - Push and pop on the same edge while full: both occur, no overflow.
//   - Pointers wrap modulo DEPTH; an occupancy counter of log2(DEPTH)+1 bits
//     decides full/empty.
//  Sticky flags: set has priority over clr_err on the same cycle.
//  Async reset mid-transfer: PSEL/PENABLE drop immediately; FIFO flushed.
// TESTING
//  1 Reset: PRESET=0 with enable=1 -> PSEL=PENABLE=PWRITE=0, smp_valid=0, all errs 0.
//  2 Basic poll: enable=1, interval=3, ADC returns 32'h1234_0000 with 0 waits
//    -> smp_data=14'h048D, smp_fs=0; next SETUP exactly 4 cycles after completion.
//  3 Saturation, 3 ADC wait states: PRDATA=32'hFFFC_0000
//    -> ACCESS holds 4 cycles, smp_data=14'h3FFF, smp_fs=1.
//  4 Timeout: TIMEOUT=16, PREADY held 0 -> abort after 16 ACCESS cycles,
//    to_err=1, no push; clr_err -> to_err=0.
//  5 Overflow: DEPTH=4, interval=0, smp_pop=0 -> 4 samples kept, 5th dropped,
//    ovf_err=1; pop concurrently with push while full -> ovf_err stays clear.
//  6 enable dropped during ACCESS with PREADY delayed 2 cycles
//    -> transfer completes, sample pushed, FSM returns to IDLE, no further SETUP.

Source files
------------

// File: rtl/adc_poll_ctrl.sv
// APB read master that polls the ADC slave at a programmed interval and
// queues the 14-bit conversion code (PRDATA[31:18]) in a small sample FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | bus quiet, waiting for enable
// S_SETUP  | APB setup phase (PSEL=1, PENABLE=0), one cycle
// S_ACCESS | APB access phase, waiting for PREADY or timeout
// S_WAIT   | bus quiet, interval down-counter running
module adc_poll_ctrl #(
  parameter int DEPTH   = 4,
  parameter int IW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          enable,
  input  logic [IW-1:0] interval,
  input  logic          clr_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  input  logic          PREADY,
  input  logic [31:0]   PRDATA,
  input  logic          PSLVERR,
  output logic          smp_valid,
  output logic [13:0]   smp_data,
  output logic          smp_fs,
  input  logic          smp_pop,
  output logic          to_err,
  output logic          slv_err,
  output logic          ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   wcnt;
  logic [IW-1:0]   icnt;
  logic            done, abort;
  logic            push, do_push, do_pop, full;

  logic [13:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  // Low data bits carry no conversion information.
  logic            unused_prdata;
  assign unused_prdata = ^PRDATA[17:0];

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE:   if (enable) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          state_nxt = S_WAIT;
        end else if (wcnt == WAIT_LAST) begin
          abort     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT:   if (icnt == '0) state_nxt = enable ? S_SETUP : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= S_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      wcnt    <= '0;
      icnt    <= '0;
    end else begin
      state   <= state_nxt;
      PSEL    <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
      PENABLE <= (state_nxt == S_ACCESS);
      if (state == S_ACCESS && !PREADY && !abort) wcnt <= wcnt + TW'(1);
      else                                         wcnt <= '0;
      // Interval is captured only when entering WAIT.
      if (state != S_WAIT && state_nxt == S_WAIT) icnt <= interval;
      else if (state == S_WAIT && icnt != '0)     icnt <= icnt - IW'(1);
    end
  end

  assign PWRITE = 1'b0;

  assign full    = (count == FULL_CNT);
  assign push    = done && !PSLVERR;
  assign do_pop  = smp_pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= PRDATA[31:18];
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set on the same edge wins over clr_err.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      to_err  <= 1'b0;
      slv_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      to_err  <= abort | (to_err & ~clr_err);
      slv_err <= (done & PSLVERR) | (slv_err & ~clr_err);
      ovf_err <= (push & full & ~do_pop) | (ovf_err & ~clr_err);
    end
  end

  assign smp_valid = (count != '0);
  assign smp_data  = smp_valid ? mem[rd_ptr] : '0;
  assign smp_fs    = smp_valid && (smp_data == 14'h3FFF);

endmodule

// File: tb/tb_adc_poll_ctrl.sv
// Directed bench for adc_poll_ctrl: the bench plays the APB slave and the
// sample consumer, expected values are hand-computed.
module tb_adc_poll_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        enable;
  logic [15:0] interval;
  logic        clr_err;
  logic        PSEL, PENABLE, PWRITE;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        smp_valid;
  logic [13:0] smp_data;
  logic        smp_fs;
  logic        smp_pop;
  logic        to_err, slv_err, ovf_err;

  int tests  = 0;
  int failed = 0;

  adc_poll_ctrl #(.DEPTH(4), .IW(16), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .interval(interval),
    .clr_err(clr_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_fs(smp_fs),
    .smp_pop(smp_pop), .to_err(to_err), .slv_err(slv_err), .ovf_err(ovf_err)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_setup(output int n);
    n = 0;
    while (!(PSEL && !PENABLE) && n < 200) begin
      tick();
      n++;
    end
    chk("setup_seen", {31'd0, PSEL && !PENABLE}, 32'd1);
  endtask

  // Called in a sampled SETUP cycle; returns number of ACCESS cycles seen.
  task automatic xfer(input int waits, input logic [31:0] data, input logic err,
                      input logic pop_done, input logic drop_en, output int k);
    PRDATA  = data;
    PSLVERR = err;
    PREADY  = 1'b0;
    tick();
    k = 0;
    for (int i = 0; i < 64; i++) begin
      if (!PENABLE) break;
      k++;
      if (drop_en && k == 1) enable = 1'b0;
      PREADY  = (k > waits);
      smp_pop = (k > waits) && pop_done;
      tick();
    end
    PREADY  = 1'b0;
    smp_pop = 1'b0;
    PSLVERR = 1'b0;
  endtask

  int n, k, bad;
  logic [13:0] exp_q [4];

  initial begin
    PRESET = 1'b0; enable = 1'b1; interval = 16'd3; clr_err = 1'b0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0; smp_pop = 1'b0;

    // Reset held with enable=1
    repeat (3) tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_errs", {to_err, slv_err, ovf_err}, 0);
    enable = 1'b0;
    PRESET = 1'b1;
    repeat (2) tick();
    chk("idle_psel", PSEL, 0);

    // Basic poll, zero waits, interval 3
    enable = 1'b1;
    wait_setup(n);
    chk("setup_latency", n, 1);
    xfer(0, 32'h1234_0000, 1'b0, 1'b0, 1'b0, k);
    chk("basic_access_cycles", k, 1);
    chk("basic_valid", smp_valid, 1);
    chk("basic_data", smp_data, 14'h048D);
    chk("basic_fs", smp_fs, 0);
    smp_pop = 1'b1;
    tick();
    smp_pop = 1'b0;
    n = 1;
    chk("basic_popped", smp_valid, 0);
    while (!(PSEL && !PENABLE) && n < 50) begin
      tick();
      n++;
    end
    chk("interval_gap", n, 4);

    // Full scale with 3 wait states
    xfer(3, 32'hFFFC_0000, 1'b0, 1'b0, 1'b0, k);
    chk("sat_access_cycles", k, 4);
    chk("sat_data", smp_data, 14'h3FFF);
    chk("sat_fs", smp_fs, 1);
    smp_pop = 1'b1;
    tick();
    smp_pop = 1'b0;

    // Timeout: PREADY never comes
    wait_setup(n);
    xfer(1000, 32'h5555_0000, 1'b0, 1'b0, 1'b0, k);
    chk("to_access_cycles", k, 16);
    chk("to_err_set", to_err, 1);
    chk("to_no_push", smp_valid, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_err_clr", to_err, 0);

    // Slave error: no push, sticky slv_err
    wait_setup(n);
    xfer(0, 32'hABCD_0000, 1'b1, 1'b0, 1'b0, k);
    chk("slv_err_set", slv_err, 1);
    chk("slv_no_push", smp_valid, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("slv_err_clr", slv_err, 0);

    // Overflow with interval 0, no pops
    interval = 16'd0;
    for (int i = 1; i <= 5; i++) begin
      wait_setup(n);
      xfer(0, {14'(i), 18'h3FFFF}, 1'b0, 1'b0, 1'b0, k);
      if (i == 4) chk("ovf_clear_at4", ovf_err, 0);
    end
    chk("ovf_set", ovf_err, 1);
    chk("ovf_head", smp_data, 14'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", ovf_err, 0);
    wait_setup(n);
    chk("wait0_one_cycle", n, 0);
    xfer(0, {14'd6, 18'h0}, 1'b0, 1'b1, 1'b0, k);
    enable = 1'b0;
    chk("push_pop_full_no_ovf", ovf_err, 0);
    exp_q[0] = 14'd2; exp_q[1] = 14'd3; exp_q[2] = 14'd4; exp_q[3] = 14'd6;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), smp_data, exp_q[i]);
      smp_pop = 1'b1;
      tick();
      smp_pop = 1'b0;
    end
    chk("drain_empty", smp_valid, 0);
    smp_pop = 1'b1;
    tick();
    smp_pop = 1'b0;
    chk("pop_empty_ignored", smp_valid, 0);
    chk("stopped_idle", PSEL, 0);

    // enable dropped during ACCESS, PREADY delayed 2 cycles
    interval = 16'd2;
    enable = 1'b1;
    wait_setup(n);
    xfer(2, 32'h8000_0000, 1'b0, 1'b0, 1'b1, k);
    chk("drop_access_cycles", k, 3);
    chk("drop_valid", smp_valid, 1);
    chk("drop_data", smp_data, 14'h2000);
    bad = 0;
    repeat (20) begin
      tick();
      if (PSEL || PENABLE) bad++;
    end
    chk("drop_no_setup", bad, 0);

    // Async reset mid-ACCESS flushes FIFO and drops the bus immediately
    enable = 1'b1;
    wait_setup(n);
    tick();
    chk("pre_rst_access", PENABLE, 1);
    #2 PRESET = 1'b0;
    #1;
    chk("arst_psel", PSEL, 0);
    chk("arst_penable", PENABLE, 0);
    chk("arst_flush", smp_valid, 0);
    enable = 1'b0;
    tick();
    PRESET = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
